// File: rtl/divider_seq_if.sv
// Handshake and result bundle for the sequential divider.
// The master drives requests; the slave (the divider) returns results.
interface divider_seq_if #(
   parameter int unsigned N = 8
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] q;
   logic [N-1:0] r;
   logic         busy;
   logic         done;
   logic         div_zero;

   modport master (
      output start, a, b,
      input  q, r, busy, done, div_zero
   );

   modport slave (
      input  start, a, b,
      output q, r, busy, done, div_zero
   );
endinterface

// File: rtl/divider_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// A zero divisor is caught in ZCHK and short-circuits straight to DONE.
module divider_seq #(
   parameter int unsigned N = 8
) (
   input logic          clk,
   input logic          sclr,
   divider_seq_if.slave bus
);
   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {StIdle, StZchk, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N:0]    rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  r_q, r_d;
   logic          dz_q, dz_d;

   logic [N:0]    shifted;
   logic          ge;

   // The extra remainder bit holds the bit shifted out, so the trial subtract never wraps.
   assign shifted = {rem_q[N-1:0], dvd_q[N-1]};
   assign ge      = (shifted >= {1'b0, dvs_q});

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StZchk;
               dvd_d   = bus.a;
               dvs_d   = bus.b;
               rem_d   = '0;
               cnt_d   = CW'(N);
            end
         end
         StZchk: begin
            if (dvs_q == '0) begin
               state_d = StDone;
               q_d     = '1;
               r_d     = dvd_q;
               dz_d    = 1'b1;
            end else begin
               state_d = StRun;
            end
         end
         StRun: begin
            rem_d = ge ? (shifted - {1'b0, dvs_q}) : shifted;
            dvd_d = {dvd_q[N-2:0], ge};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = StDone;
               q_d     = {dvd_q[N-2:0], ge};
               r_d     = rem_d[N-1:0];
               dz_d    = 1'b0;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q <= StIdle;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.r        = r_q;
   assign bus.div_zero = dz_q;
   assign bus.busy     = (state_q == StZchk) || (state_q == StRun);
   assign bus.done     = (state_q == StDone);
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: a latency/arithmetic model checked every cycle,
// directed literal cases and 1000 randomized divisions.
module tb_divider_seq;
   localparam int unsigned N = 8;

   logic clk = 1'b0;
   logic sclr;

   divider_seq_if #(.N(N)) bus ();

   divider_seq #(.N(N)) dut (
      .clk  (clk),
      .sclr (sclr),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int prints = 0;
   int dut_ndone = 0;
   bit chk_en = 1'b0;

   // Model: an accepted operation at edge e publishes a/b, a%b at a fixed later edge.
   int unsigned  ecount = 0;
   int unsigned  m_free = 0;
   int unsigned  m_load = 0;
   bit           m_pend = 1'b0;
   logic [N-1:0] m_pq = '0, m_pr = '0;
   logic         m_pdz = 1'b0;
   logic [N-1:0] m_q = '0, m_r = '0;
   logic         m_dz = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   int           m_ndone = 0;

   always @(posedge clk) begin
      ecount <= ecount + 1;
      if (sclr) begin
         m_pend <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_dz   <= 1'b0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_free <= ecount + 1;
      end else if (m_pend && ecount == m_load) begin
         m_pend  <= 1'b0;
         m_q     <= m_pq;
         m_r     <= m_pr;
         m_dz    <= m_pdz;
         m_busy  <= 1'b0;
         m_done  <= 1'b1;
         m_ndone <= m_ndone + 1;
      end else if (bus.start && ecount >= m_free) begin
         m_pend <= 1'b1;
         m_busy <= 1'b1;
         m_done <= 1'b0;
         if (bus.b == '0) begin
            m_pq   <= '1;
            m_pr   <= bus.a;
            m_pdz  <= 1'b1;
            m_load <= ecount + 1;
            m_free <= ecount + 3;
         end else begin
            m_pq   <= bus.a / bus.b;
            m_pr   <= bus.a % bus.b;
            m_pdz  <= 1'b0;
            m_load <= ecount + N + 1;
            m_free <= ecount + N + 3;
         end
      end else begin
         m_busy <= m_pend;
         m_done <= 1'b0;
      end
   end

   // One cycle step: every output is compared against the model at the falling edge.
   task automatic tick();
      @(negedge clk);
      if (chk_en) begin
         tests++;
         if (bus.busy !== m_busy || bus.done !== m_done || bus.q !== m_q ||
             bus.r !== m_r || bus.div_zero !== m_dz) begin
            fails++;
            if (prints < 20) begin
               prints++;
               $display("FAIL cycle_model t=%0t: got busy=%b done=%b q=%0d r=%0d dz=%b, want busy=%b done=%b q=%0d r=%0d dz=%b",
                        $time, bus.busy, bus.done, bus.q, bus.r, bus.div_zero,
                        m_busy, m_done, m_q, m_r, m_dz);
            end
         end
         if (bus.done === 1'b1) dut_ndone++;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic start_op(input int unsigned a, input int unsigned b);
      bus.start = 1'b1;
      bus.a     = N'(a);
      bus.b     = N'(b);
   endtask

   // Drops start after E0, scrambles operands, waits (bounded) for done, then one idle cycle.
   task automatic wait_done(output int lat, output int nbusy);
      lat   = -1;
      nbusy = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (i == 1) begin
            bus.start = 1'b0;
            bus.a     = N'($urandom);
            bus.b     = N'($urandom);
         end
         if (bus.busy === 1'b1) nbusy++;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      tick();
   endtask

   task automatic idle(input int n, output int nd);
      int d0;
      d0 = dut_ndone;
      for (int i = 0; i < n; i++) tick();
      nd = dut_ndone - d0;
   endtask

   int lat, nb, nd;
   int unsigned ra, rb;

   initial begin
      sclr      = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("reset_q", int'(bus.q), 0);
      chk("reset_flags", int'({bus.busy, bus.done, bus.div_zero}), 0);
      sclr = 1'b0;
      tick();

      start_op(200, 7);
      wait_done(lat, nb);
      chk("200_7_latency", lat, 10);
      chk("200_7_busy_cycles", nb, 9);
      chk("200_7_q", int'(bus.q), 28);
      chk("200_7_r", int'(bus.r), 4);
      chk("200_7_dz", int'(bus.div_zero), 0);

      start_op(255, 1);
      wait_done(lat, nb);
      idle(10, nd);
      chk("255_1_q_hold", int'(bus.q), 255);
      chk("255_1_r_hold", int'(bus.r), 0);
      start_op(5, 9);
      wait_done(lat, nb);
      idle(10, nd);
      chk("5_9_q_hold", int'(bus.q), 0);
      chk("5_9_r_hold", int'(bus.r), 5);

      start_op(77, 0);
      wait_done(lat, nb);
      chk("77_0_latency", lat, 2);
      chk("77_0_q", int'(bus.q), 255);
      chk("77_0_r", int'(bus.r), 77);
      chk("77_0_dz", int'(bus.div_zero), 1);
      start_op(10, 3);
      wait_done(lat, nb);
      chk("10_3_q", int'(bus.q), 3);
      chk("10_3_r", int'(bus.r), 1);
      chk("10_3_dz", int'(bus.div_zero), 0);

      // A second start mid-RUN must be dropped, not queued.
      start_op(200, 7);
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      start_op(1, 1);
      tick();
      bus.start = 1'b0;
      wait_done(lat, nb);
      chk("midrun_done_seen", int'(lat > 0), 1);
      chk("midrun_q", int'(bus.q), 28);
      chk("midrun_r", int'(bus.r), 4);
      idle(15, nd);
      chk("midrun_no_extra_done", nd, 0);

      start_op(50, 6);
      idle(40, nd);
      bus.start = 1'b0;
      idle(15, lat);
      chk("held_start_dones", nd + lat, 4);
      chk("held_q", int'(bus.q), 8);
      chk("held_r", int'(bus.r), 2);

      // Abort in the 4th RUN cycle.
      start_op(123, 5);
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      chk("abort_q", int'(bus.q), 0);
      chk("abort_r", int'(bus.r), 0);
      chk("abort_flags", int'({bus.busy, bus.done, bus.div_zero}), 0);
      idle(15, nd);
      chk("abort_no_done", nd, 0);
      start_op(100, 10);
      wait_done(lat, nb);
      chk("100_10_q", int'(bus.q), 10);
      chk("100_10_r", int'(bus.r), 0);

      for (int k = 0; k < 1000; k++) begin
         ra = $urandom_range(0, (1 << N) - 1);
         rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << N) - 1);
         start_op(ra, rb);
         wait_done(lat, nb);
         chk("rand_latency", lat, (rb == 0) ? 2 : N + 2);
         if (rb == 0) begin
            chk("rand_zero_q_r", int'({bus.q, bus.r}), int'({N'((1 << N) - 1), N'(ra)}));
         end else begin
            chk("rand_relation", int'(bus.q) * int'(rb) + int'(bus.r) == int'(ra) &&
                int'(bus.r) < int'(rb) ? 1 : 0, 1);
         end
         idle(int'($urandom_range(0, 3)), nd);
      end
      chk("done_count", dut_ndone, m_ndone);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have parameter N, default 8: operand width in bits, N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port sclr, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N bits: unsigned dividend, sampled with start.
REQ-006 The block SHALL have port b, input, N bits: unsigned divisor, sampled with start.
REQ-007 The block SHALL have port q, output, N bits: quotient, registered.
REQ-008 The block SHALL have port r, output, N bits: remainder, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in state RUN or ZCHK.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking new q/r/div_zero values.
REQ-011 The block SHALL have port div_zero, output, 1 bit: high when the last completed operation had b == 0.

Function
REQ-012 The block SHALL implement a restoring shift-subtract unsigned division, one quotient bit per clock.
REQ-013 The FSM SHALL have four states: IDLE, ZCHK, RUN, DONE.
REQ-014 The FSM SHALL make these transitions: IDLE -> ZCHK on start; ZCHK -> DONE if the captured b == 0, else ZCHK -> RUN; RUN -> DONE after N iterations; DONE -> IDLE unconditionally.
REQ-015 On the start edge (E0), the block SHALL capture a and b into internal working registers, clear the partial remainder (N+1 bits) and load the iteration counter with N.
REQ-016 Each RUN edge SHALL shift {rem, dividend} left by one, trial-subtract divisor from rem, keep the difference and set the quotient LSB to 1 if the difference is non-negative, else restore and set 0, then decrement the counter.
REQ-017 The partial remainder SHALL be N+1 bits wide so that the trial subtraction never overflows.
REQ-018 Latency: for b != 0, q/r SHALL be loaded at edge E(N+1) and done SHALL be high in the cycle after E(N+1).
REQ-019 Latency: for b == 0, q/r SHALL be loaded at edge E1 and done SHALL be high in the cycle after E1.
REQ-020 For b == 0, the block SHALL set q = {N{1'b1}}, r = captured a and div_zero = 1.
REQ-021 For b != 0, the result SHALL satisfy a == q*b + r with r < b, and div_zero = 0.
REQ-022 q, r and div_zero SHALL change only at the loading edge of a completed operation and hold otherwise, including through later IDLE cycles.
REQ-023 done SHALL be high for exactly one cycle per accepted start.
REQ-024 busy SHALL be low in IDLE and DONE.
REQ-025 start SHALL be ignored in ZCHK, RUN and DONE, with no queuing; a start held high continuously SHALL re-launch from IDLE, one operation per N+3 cycles (b != 0).
REQ-026 Changes on a or b after E0 SHALL have no effect on the running operation.

Reset
REQ-027 While sclr = 1 at a clock edge, the block SHALL set state = IDLE and q = 0, r = 0, busy = 0, done = 0, div_zero = 0, and clear the working registers and counter.
REQ-028 sclr SHALL take priority over start in the same cycle.
REQ-029 sclr asserted mid-RUN SHALL abort the operation without producing a done pulse.
REQ-030 After sclr deasserts, the first start SHALL be accepted normally.

Verification
REQ-031 The bench SHALL check, with N=8: start with a=200, b=7 -> busy for 9 cycles, then done pulse with q=28, r=4, div_zero=0.
REQ-032 The bench SHALL check: a=255, b=1 -> q=255, r=0; then a=5, b=9 -> q=0, r=5; q/r hold unchanged for 10 idle cycles after each.
REQ-033 The bench SHALL check: a=77, b=0 -> done in the cycle after E1, q=8'hFF, r=77, div_zero=1; a following a=10, b=3 -> q=3, r=1, div_zero=0.
REQ-034 The bench SHALL check: start pulsed again during RUN with different a/b -> ignored, and the first result is correct; start held high for 40 cycles -> exactly 4 done pulses for b != 0.
REQ-035 The bench SHALL check: sclr asserted at the 4th RUN cycle -> no done pulse, all outputs 0 on the next cycle; the next start with a=100, b=10 -> q=10, r=0.
REQ-036 The bench SHALL check: random a, b (including b=0) for 1000 operations against a reference model for the q/r/div_zero relation and the done count.
